// File: rtl/store_rmw_sequencer.sv
// store_rmw_sequencer: sequences SB/SH read-modify-write and SW direct stores into a byte-enable-less single-port RAM.
module store_rmw_sequencer #(
  parameter int RD_LATENCY = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [2:0]  iFUNC3,
  input  logic [31:0] iADDR,
  input  logic [31:0] iWDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oMISALIGN,
  output logic        oILLEGAL,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  input  logic [31:0] iRAM_DATA,
  output logic [31:0] oRAM_DATA
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  logic [2:0]  state, nxt, func3;
  logic [1:0]  cnt;
  logic [31:0] addr, wdata;
  logic        ill, mis, last_wait, accept;
  function automatic logic [31:0] merge(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w, input logic [31:0] r);
    logic [31:0] m;
    m = r;
    if (f == 3'd0) m[{a, 3'b000} +: 8] = w[7:0];
    else if (f == 3'd1) m[{a[1], 4'b0000} +: 16] = w[15:0];
    else m = w;
    return m;
  endfunction
  assign ill       = iFUNC3 > 3'd2;
  assign mis       = (iFUNC3 == 3'd1 && iADDR[0]) || (iFUNC3 == 3'd2 && iADDR[1:0] != 2'b00);
  assign last_wait = state == WAIT && cnt == 2'(RD_LATENCY - 1);
  assign accept    = state == IDLE && iSTART;
  always_comb begin
    nxt = state == IDLE  ? (iSTART ? ((ill || mis) ? DONE : iFUNC3 == 3'd2 ? WRITE : READ) : IDLE)
        : state == READ  ? WAIT
        : state == WAIT  ? (last_wait ? WRITE : WAIT)
        : state == WRITE ? DONE : IDLE;
  end
  // Strobes and bus values are registered from the next state so they line up with that state's cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      func3     <= 3'd0;
      addr      <= 32'd0;
      wdata     <= 32'd0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oMISALIGN <= 1'b0;
      oILLEGAL  <= 1'b0;
      oRAM_CE   <= 1'b0;
      oRAM_RD   <= 1'b0;
      oRAM_WR   <= 1'b0;
      oRAM_ADDR <= 32'd0;
      oRAM_DATA <= 32'd0;
    end else begin
      state     <= nxt;
      cnt       <= state == WAIT ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        func3 <= iFUNC3;
        addr  <= iADDR;
        wdata <= iWDATA;
      end
      oBUSY     <= nxt != IDLE;
      oDONE     <= nxt == DONE;
      oMISALIGN <= accept && mis;
      oILLEGAL  <= accept && ill;
      oRAM_CE   <= nxt == READ || nxt == WRITE;
      oRAM_RD   <= nxt == READ;
      oRAM_WR   <= nxt == WRITE;
      if (nxt == READ || nxt == WRITE) oRAM_ADDR <= {(state == IDLE ? iADDR[31:2] : addr[31:2]), 2'b00};
      if (nxt == WRITE) oRAM_DATA <= state == IDLE ? iWDATA : merge(func3, addr[1:0], wdata, iRAM_DATA);
    end
  end
endmodule

// File: tb/tb_store_rmw_sequencer.sv
// tb_store_rmw_sequencer: checks two sequencers (read latency 1 and 3) against a timeline model of each store.
module tb_store_rmw_sequencer;
  localparam int L0 = 1, L1 = 3;
  logic clk = 0, rst = 1, start = 0, reload = 0, armed = 0;
  logic [2:0] func3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic busy[2], done[2], mis[2], ill[2], ce[2], rd[2], wr[2];
  logic [31:0] ra[2], wd[2];
  logic [31:0] ram[2][1024];
  logic [31:0] pipe[2][4];
  logic [31:0] mmem[2][1024];
  int lat[2] = '{L0, L1};
  int t[2] = '{0, 0}, len[2], rcyc[2], wcyc[2];
  logic [31:0] exp_wa[2], exp_wd[2];
  logic exp_mis[2], exp_ill[2];
  int cyc = 0, st = 0, errors = 0, checks = 0;
  int wrcnt[2] = '{0, 0}, rdcnt[2] = '{0, 0}, cecnt[2] = '{0, 0}, donecnt[2] = '{0, 0}, donecyc[2];
  logic [31:0] lastwr[2], lastwa[2];
  logic dmis[2], dill[2];
  always #5 clk = ~clk;
  store_rmw_sequencer #(.RD_LATENCY(L0)) u0 (.iCLK(clk), .iRST(rst), .iSTART(start), .iFUNC3(func3), .iADDR(addr),
    .iWDATA(wdata), .oBUSY(busy[0]), .oDONE(done[0]), .oMISALIGN(mis[0]), .oILLEGAL(ill[0]), .oRAM_CE(ce[0]),
    .oRAM_RD(rd[0]), .oRAM_WR(wr[0]), .oRAM_ADDR(ra[0]), .iRAM_DATA(pipe[0][L0-1]), .oRAM_DATA(wd[0]));
  store_rmw_sequencer #(.RD_LATENCY(L1)) u1 (.iCLK(clk), .iRST(rst), .iSTART(start), .iFUNC3(func3), .iADDR(addr),
    .iWDATA(wdata), .oBUSY(busy[1]), .oDONE(done[1]), .oMISALIGN(mis[1]), .oILLEGAL(ill[1]), .oRAM_CE(ce[1]),
    .oRAM_RD(rd[1]), .oRAM_WR(wr[1]), .oRAM_ADDR(ra[1]), .iRAM_DATA(pipe[1][L1-1]), .oRAM_DATA(wd[1]));
  // RAM: read data appears exactly RD_LATENCY cycles after the read cycle, garbage otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr[k]) ram[k][ra[k][11:2]] <= wd[k];
      if (reload) ram[k][64] <= 32'h11223344;
      for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
      pipe[k][0] <= rd[k] ? ram[k][ra[k][11:2]] : 32'hBAD0BAD0;
    end
  end
  function automatic logic [31:0] merge_model(input logic [2:0] f, input int a, input logic [31:0] w, input logic [31:0] old);
    logic [7:0] b[4];
    if (f == 3'd2) return w;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    b[a] = w[7:0];
    if (f == 3'd1) b[a+1] = w[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (t[k] > 0 && t[k] == wcyc[k]) mmem[k][exp_wa[k][11:2]] = exp_wd[k];
      if (reload) mmem[k][64] = 32'h11223344;
      if (rst) t[k] = 0;
      else if (t[k] == 0) begin
        if (start) begin
          exp_ill[k] = func3 > 2;
          exp_mis[k] = (func3 == 1 && addr % 2 != 0) || (func3 == 2 && addr % 4 != 0);
          exp_wa[k]  = addr & ~32'd3;
          exp_wd[k]  = merge_model(func3, int'(addr % 4), wdata, mmem[k][addr[11:2]]);
          if (exp_ill[k] || exp_mis[k]) begin len[k] = 1; rcyc[k] = 0; wcyc[k] = 0; end
          else if (func3 == 2) begin len[k] = 2; rcyc[k] = 0; wcyc[k] = 1; end
          else begin len[k] = lat[k] + 3; rcyc[k] = 1; wcyc[k] = lat[k] + 2; end
          t[k] = 1;
        end
      end else t[k] = t[k] == len[k] ? 0 : t[k] + 1;
    end
  end
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic er, ew, ed;
        er = t[k] > 0 && t[k] == rcyc[k];
        ew = t[k] > 0 && t[k] == wcyc[k];
        ed = t[k] > 0 && t[k] == len[k];
        chk("ctl", k, {25'd0, busy[k], done[k], mis[k], ill[k], ce[k], rd[k], wr[k]},
            {25'd0, t[k] > 0, ed, ed && exp_mis[k], ed && exp_ill[k], er || ew, er, ew});
        if (er || ew) chk("ram_addr", k, ra[k], exp_wa[k]);
        if (ew) chk("ram_data", k, wd[k], exp_wd[k]);
        if (wr[k]) begin wrcnt[k]++; lastwr[k] = wd[k]; lastwa[k] = ra[k]; end
        if (rd[k]) rdcnt[k]++;
        if (ce[k]) cecnt[k]++;
        if (done[k]) begin donecnt[k]++; donecyc[k] = cyc; dmis[k] = mis[k]; dill[k] = ill[k]; end
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (t[0] == 0 && t[1] == 0) return;
      @(negedge clk);
    end
    errors++;
    checks++;
    $display("FAIL idle_timeout: model still busy after 30 cycles");
  endtask
  task automatic do_reload();
    @(negedge clk); reload = 1;
    @(negedge clk); reload = 0;
  endtask
  task automatic go(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    @(negedge clk); func3 = f; addr = a; wdata = w; start = 1; st = cyc;
    @(negedge clk); start = 0;
    wait_idle();
  endtask
  int wb, db, cb, rb;
  initial begin
    @(negedge clk);
    armed = 1;
    for (int k = 0; k < 2; k++)
      chk("reset_out", k, {busy[k], done[k], mis[k], ill[k], ce[k], rd[k], wr[k], 25'd0} | ra[k] | wd[k], 32'd0);
    rst = 0;
    do_reload();
    go(3'd0, 32'h101, 32'h000000AB);
    for (int k = 0; k < 2; k++) begin
      chk("sb_data", k, lastwr[k], 32'h1122AB44);
      chk("sb_addr", k, lastwa[k], 32'h100);
    end
    chk("sb_latency", 0, donecyc[0] - st, 4);
    chk("sb_latency", 1, donecyc[1] - st, 6);
    do_reload();
    go(3'd1, 32'h102, 32'h0000BEEF);
    chk("sh_hi", 0, lastwr[0], 32'hBEEF3344);
    do_reload();
    go(3'd1, 32'h100, 32'h0000BEEF);
    chk("sh_lo", 1, lastwr[1], 32'h1122BEEF);
    rb = rdcnt[0];
    go(3'd2, 32'h200, 32'hDEADBEEF);
    chk("sw_data", 0, lastwr[0], 32'hDEADBEEF);
    chk("sw_addr", 0, lastwa[0], 32'h200);
    chk("sw_latency", 0, donecyc[0] - st, 2);
    chk("sw_no_rd", 0, rdcnt[0], rb);
    chk("sw_flags", 0, {dmis[0], dill[0]}, 0);
    cb = cecnt[1];
    go(3'd1, 32'h103, 32'h1234);
    chk("sh_mis_latency", 1, donecyc[1] - st, 1);
    chk("sh_mis_flags", 1, {dmis[1], dill[1]}, 2'b10);
    go(3'd2, 32'h202, 32'h1234);
    chk("sw_mis_flags", 0, {dmis[0], dill[0]}, 2'b10);
    go(3'd5, 32'h100, 32'h1234);
    chk("ill_flags", 0, {dmis[0], dill[0]}, 2'b01);
    chk("fault_no_ce", 1, cecnt[1], cb);
    do_reload();
    wb = wrcnt[0]; db = donecnt[0];
    @(negedge clk); func3 = 3'd0; addr = 32'h101; wdata = 32'h55; start = 1; st = cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); func3 = 3'd2; addr = 32'h300; wdata = 32'hFFFFFFFF; start = 1;
    end
    @(negedge clk); start = 0;
    wait_idle();
    chk("repulse_wr", 0, wrcnt[0], wb + 1);
    chk("repulse_done", 0, donecnt[0], db + 1);
    chk("repulse_data", 0, lastwr[0], 32'h11225544);
    chk("repulse_data", 1, lastwr[1], 32'h11225544);
    wb = wrcnt[1]; db = donecnt[1];
    @(negedge clk); func3 = 3'd0; addr = 32'h101; wdata = 32'h66; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int k = 0; k < 2; k++)
      chk("rst_mid", k, {busy[k], done[k], mis[k], ill[k], ce[k], rd[k], wr[k], 25'd0} | ra[k] | wd[k], 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_no_wr", 1, wrcnt[1], wb);
    chk("rst_no_done", 1, donecnt[1], db);
    go(3'd2, 32'h200, 32'h12345678);
    chk("post_rst_sw", 1, lastwr[1], 32'h12345678);
    chk("post_rst_latency", 1, donecyc[1] - st, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
